shiftreg_sipo_rx: RTL
=====================

# shiftreg_sipo_rx

Serial-in, parallel-out word receiver: the receive end of the LSB-first, right-shifting serial link driven by the parallel-in serial-out shift register. It arms on a `start` pulse, samples `ser_in` on each `enable` strobe, and after W bits presents the assembled word with a one-cycle `valid` pulse. It is used wherever serialized board data (piece codes, row masks) must be reassembled into parallel words.

## Interface
- `W`, default 8: data word width in bits. Must be ≥ 2.

- `clk` in 1: system clock; all state updates on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `ser_in` in 1: serial data, LSB first. Sampled only when `enable` = 1.
- `enable` in 1: bit strobe. One bit is consumed per cycle in which it is high.
- `start` in 1: frame start pulse. Arms, or re-arms, the receiver.
- `word` out W: last completed word. Held until the next completion.
- `valid` out 1: high for exactly one cycle when `word` updates.
- `busy` out 1: high while a frame is in progress (states SHIFT and PARITY).
- `parity_err` out 1: parity result for the last word. Held with `word`.

## Operation
- Internal state:
  - `sr` [W-1:0]: shift register.
  - `cnt`: bit counter, width $clog2(W+1).
  - `state`: one of IDLE, SHIFT, PARITY.
- Reset: `clear` = 1 at an edge forces:
  - state = IDLE; `sr`, `cnt`, `word` = 0;
  - `valid`, `busy`, `parity_err` = 0.
  - `clear` overrides every other input and aborts any frame in progress.
- IDLE:
  - `enable` is ignored.
  - `start` = 1 → SHIFT, with `sr` = 0 and `cnt` = 0.
  - `start` only arms the receiver. The first bit is sampled on the first `enable` edge strictly after the `start` edge; `enable` in the `start` cycle is ignored.
- SHIFT, on `enable` = 1:
  - `sr` <= {`ser_in`, `sr`[W-1:1]} and `cnt` <= `cnt` + 1.
  - On the W-th bit (`cnt` == W-1):
    - Without parity: `word` <= {`ser_in`, `sr`[W-1:1]}, `valid` <= 1, state → IDLE.
    - With parity: state → PARITY.
  - After completion, `word`[0] holds the first bit received and `word`[W-1] the last.
- PARITY (only with the macro defined), on `enable` = 1:
  - `word` <= `sr`, `parity_err` <= (^`sr`) ^ `ser_in` (even parity), `valid` <= 1, state → IDLE.
- `start` while `busy` = 1:
  - The partial frame is discarded and no `valid` is produced.
  - `sr` and `cnt` are zeroed and the state stays in, or returns to, SHIFT.
  - `start` takes priority over a coincident `enable`, including the final-bit `enable`.
- A `start` in the cycle `valid` is high is legal, since the state is already IDLE. This allows back-to-back frames with no dead cycle beyond the start cycle.
- Cycles with `enable` = 0 inside a frame: all state holds. There is no timeout.

## Timing
- All outputs are registered.
- Latency: `valid` rises after the edge that samples the last bit (data bit W, or the parity bit) and falls at the following edge.
- `word` and `parity_err` change only on the edge that raises `valid`.
- `busy` rises the edge after `start` and falls on the same edge that raises `valid`.
- Minimum frame length:
  - 1 + W cycles (start plus W enables).
  - 1 + W + 1 cycles with parity.

## Configuration
- `PARITY_CHECK_EN` defined:
  - A frame is W data bits followed by one even-parity bit.
  - The PARITY state exists and `parity_err` reports mismatch.
- Not defined:
  - A frame is W bits and the PARITY state is not built.
  - `parity_err` is tied to 0.

## Test plan
All scenarios use W = 8.
1. `clear`, `start`, then 8 consecutive `enable` cycles with bits 0,0,0,0,1,1,0,1 → `word` = 8'hB0, `valid` high for exactly one cycle after the 8th enable edge, `busy` falls on that same edge.
2. Same frame with `enable` low on alternate cycles → `word` = 8'hB0, one `valid` pulse, timed from the last enable edge.
3. `start`, 3 bits, `start` again, then 8 bits of 8'h5A → single `valid`, `word` = 8'h5A, no earlier pulse. Separately, `start` coincident with the 8th `enable` → no `valid`.
4. `clear` after 5 bits → `busy` = 0, `word` = 0, no `valid`; a following full frame of 8'hFF gives `word` = 8'hFF.
5. `enable` toggling in IDLE without `start` → `busy` stays 0, `word` unchanged, no `valid`.
6. `PARITY_CHECK_EN`: frame 8'hB0 plus parity bit 1 → `parity_err` = 0; plus parity bit 0 → `parity_err` = 1. `valid` follows the 9th enable in both cases.

Source files
------------

// File: rtl/shiftreg_sipo_rx.sv
// shiftreg_sipo_rx: LSB-first serial-in parallel-out word receiver with start/enable framing.
// Optional even-parity bit after each word when PARITY_CHECK_EN is defined.
`default_nettype none

module shiftreg_sipo_rx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         ser_in,
  input  logic         enable,
  input  logic         start,
  output logic [W-1:0] word,
  output logic         valid,
  output logic         busy,
  output logic         parity_err
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef PARITY_CHECK_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  logic [1:0]    state;
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  sr_next;

  assign sr_next = {ser_in, sr[W-1:1]};

`ifdef PARITY_CHECK_EN
  logic parity_q;
  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clear) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      word  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_q <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      // start (re)arms from any state and wins over a coincident enable
      if (start) begin
        state <= SHIFT;
        sr    <= '0;
        cnt   <= '0;
        busy  <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          SHIFT: begin
            if (enable) begin
              sr  <= sr_next;
              cnt <= cnt + CW'(1);
              if (cnt == LAST_BIT) begin
`ifdef PARITY_CHECK_EN
                state <= PARITY;
`else
                word  <= sr_next;
                valid <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
`endif
              end
            end
          end
`ifdef PARITY_CHECK_EN
          PARITY: begin
            if (enable) begin
              word     <= sr;
              parity_q <= (^sr) ^ ser_in;
              valid    <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
`endif
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
